divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Iterative restoring divider, the inverse operation of the team's combinational array multiplier.
- Computes quotient and remainder of two N-bit unsigned operands, one quotient bit per clock.
- Uses a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath, so a product P = A×B can be checked back as P/B.

Parameters:
- N, 8, operand width in bits (≥2); dividend, divisor, quotient and remainder are all N bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  N  numerator, captured on accepted start.
- divisor  input  N  denominator, captured on accepted start.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  single-cycle pulse: results are valid.
- quotient  output  N  result, held until next accepted start.
- remainder  output  N  result, held until next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held with results.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and registers cleared.
- Reset mid-operation aborts immediately; no done pulse is produced for the aborted operation.
- States:
  - IDLE: start=1 latches operands; go to RUN (divisor≠0) or DZ (divisor==0).
  - RUN: N iterations using the restoring step below.
  - DZ: one cycle; next state FIN.
  - FIN: done=1 for exactly one cycle; busy=0; return to IDLE.
- Restoring step (partial remainder R is N+1 bits, shift register Q holds the dividend):
  - R' = {R[N-1:0], Q[N-1]}; Q shifts left.
  - If R' ≥ {1'b0, divisor}: R = R' − divisor, Q[0]=1. Otherwise R = R', Q[0]=0.
  - Iteration counter runs N−1 down to 0; RUN → FIN after the count-0 step.
- Latency, with the accept edge as cycle 0:
  - busy=1 on cycles 1..N.
  - done=1 on cycle N+1.
  - quotient/remainder update on the same edge that raises done.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1; done on cycle 2.
- start while busy or in FIN: ignored, no queuing.
- start in the same cycle done is high: ignored. An accept needs IDLE, so the earliest next accept is the cycle after done.
- Outputs are stable between done pulses; div_by_zero clears on the next accepted start.
- Invariant for unsigned mode: quotient×divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Latch |dividend| and |divisor|, then run the same unsigned core.
  - Quotient is negated if the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Corner case MIN/−1: quotient = MIN (0x80 for N=8), remainder = 0, div_by_zero=0.
  - Divide by zero: quotient = all ones (−1), remainder = dividend.
  - Sign fix-up is folded into the FIN transition; latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Package div_pkg:
  - State enum (IDLE, RUN, DZ, FIN).
  - Function for counter width, $clog2(N).
  - Constant for the divide-by-zero quotient pattern.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: R, Q, divisor. Outputs: R_next, Q_next.
  - Reusable later for an unrolled/pipelined divider.
- The FSM, counter and registers stay in divider_seq.

Test Plan:
- N=8, dividend=200, divisor=7 → quotient=28, remainder=4; done exactly at cycle 9; busy high cycles 1..8.
- N=8, 255/255 → q=1, r=0. Then 5/9 → q=0, r=5. Then 0/3 → q=0, r=0.
- N=8, 13/0 → q=255, r=13, div_by_zero=1; done at cycle 2. The following 40/8 → q=5, r=0, div_by_zero=0.
- N=8, start 100/3, pulse start again with 50/5 on cycle 4 → second request ignored; result q=33, r=1. Start asserted during done is also ignored.
- N=16, 54321/123 → q=441, r=78; done at cycle 17. A second run starting at 200/7 is reset with rst_n=0 on cycle 5 → all outputs 0 immediately, no done pulse.
- DIVIDER_SIGNED_EN, N=8:
  - 0x9C/0x07 (−100/7) → q=0xF2 (−14), r=0xFE (−2).
  - 0x80/0xFF → q=0x80, r=0x00.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2,
        FIN  = 2'd3
    } div_state_e;

    // Divide-by-zero quotient: all ones, sliced to the operand width at use.
    localparam logic [63:0] DZ_QUOTIENT = {64{1'b1}};

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface divider_seq_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration; reusable for unrolled dividers.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);
    logic [N:0] r_shift_s;
    logic       unused_s;

    // The partial remainder entering a step is always below the divisor, so its MSB is never needed.
    assign r_shift_s = {r[N-1:0], q[N-1]};
    assign unused_s  = r[N];

    // Trial subtraction: keep the difference and set the quotient bit if it fits.
    always_comb begin
        if (r_shift_s >= {1'b0, divisor}) begin
            r_next = r_shift_s - {1'b0, divisor};
            q_next = {q[N-2:0], 1'b1};
        end else begin
            r_next = r_shift_s;
            q_next = {q[N-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider_seq
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    divider_seq_if.slave  bus
);
    localparam int CW = cnt_width(N);

    div_state_e   state_r, state_s;
    logic [CW-1:0] cnt_r;
    logic [N:0]   r_r, r_next_s;
    logic [N-1:0] q_r, q_next_s, dvs_r, dvd_r;
    logic [N-1:0] dvd_abs_s, dvs_abs_s, quo_fin_s, rem_fin_s;
    logic [N-1:0] quo_r, rem_r;
    logic         busy_r, done_r, dbz_r;

    div_step #(.N(N)) u_step (
        .r       (r_r),
        .q       (q_r),
        .divisor (dvs_r),
        .r_next  (r_next_s),
        .q_next  (q_next_s)
    );

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_r, neg_r_r;

    assign dvd_abs_s = bus.dividend[N-1] ? ({N{1'b0}} - bus.dividend) : bus.dividend;
    assign dvs_abs_s = bus.divisor[N-1]  ? ({N{1'b0}} - bus.divisor)  : bus.divisor;
    // MIN/-1 needs no special case: |MIN| = MIN and the quotient is not negated.
    assign quo_fin_s = neg_q_r ? ({N{1'b0}} - q_next_s) : q_next_s;
    assign rem_fin_s = neg_r_r ? ({N{1'b0}} - r_next_s[N-1:0]) : r_next_s[N-1:0];
`else
    assign dvd_abs_s = bus.dividend;
    assign dvs_abs_s = bus.divisor;
    assign quo_fin_s = q_next_s;
    assign rem_fin_s = r_next_s[N-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = (bus.divisor == {N{1'b0}}) ? DZ : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            DZ:      state_s = FIN;
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath, iteration counter and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            r_r    <= {(N+1){1'b0}};
            q_r    <= {N{1'b0}};
            dvs_r  <= {N{1'b0}};
            dvd_r  <= {N{1'b0}};
            quo_r  <= {N{1'b0}};
            rem_r  <= {N{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            busy_r <= (state_s == RUN) || (state_s == DZ);
            done_r <= (state_s == FIN);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        r_r   <= {(N+1){1'b0}};
                        q_r   <= dvd_abs_s;
                        dvs_r <= dvs_abs_s;
                        dvd_r <= bus.dividend;
                        cnt_r <= CW'(N - 1);
                        dbz_r <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        neg_q_r <= bus.dividend[N-1] ^ bus.divisor[N-1];
                        neg_r_r <= bus.dividend[N-1];
`endif
                    end
                end
                RUN: begin
                    r_r   <= r_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == {CW{1'b0}}) begin
                        quo_r <= quo_fin_s;
                        rem_r <= rem_fin_s;
                    end
                end
                DZ: begin
                    quo_r <= DZ_QUOTIENT[N-1:0];
                    rem_r <= dvd_r;
                    dbz_r <= 1'b1;
                end
                FIN: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq at N=8 and N=16 (signed cases under DIVIDER_SIGNED_EN).
module tb_divider_seq;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    logic clk;
    logic rst8_n, rst16_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb8[$];
    exp_t sb16[$];

    divider_seq_if #(.N(8))  bus8();
    divider_seq_if #(.N(16)) bus16();

    divider_seq #(.N(8))  u_div8  (.clk(clk), .rst_n(rst8_n),  .bus(bus8));
    divider_seq #(.N(16)) u_div16 (.clk(clk), .rst_n(rst16_n), .bus(bus16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          sa, sb;
        logic [15:0] mask;
        mask = (w == 8) ? 16'h00ff : 16'hffff;
`ifdef DIVIDER_SIGNED_EN
        sa = (w == 8) ? int'($signed(a[7:0])) : int'($signed(a));
        sb = (w == 8) ? int'($signed(b[7:0])) : int'($signed(b));
`else
        sa = int'(a & mask);
        sb = int'(b & mask);
`endif
        if (sb == 0) begin
            e.q = mask; e.r = a & mask; e.dbz = 1'b1;
        end else begin
            e.q = 16'(sa / sb) & mask; e.r = 16'(sa % sb) & mask; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus8.done === 1'b1) begin
            if (sb8.size() == 0) begin
                chk("sb8_extra_done", 32'(sb8.size()), 32'd1);
            end else begin
                e = sb8.pop_front();
                chk("q8",   32'(bus8.quotient),    32'(e.q));
                chk("r8",   32'(bus8.remainder),   32'(e.r));
                chk("dbz8", 32'(bus8.div_by_zero), 32'(e.dbz));
            end
        end
        if (bus16.done === 1'b1) begin
            if (sb16.size() == 0) begin
                chk("sb16_extra_done", 32'(sb16.size()), 32'd1);
            end else begin
                e = sb16.pop_front();
                chk("q16",   32'(bus16.quotient),    32'(e.q));
                chk("r16",   32'(bus16.remainder),   32'(e.r));
                chk("dbz16", 32'(bus16.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int inj, input bit sdone);
        int cyc, busy_bad, lat;
        bit seen;
        lat = (b == 8'd0) ? 2 : 9;
        @(negedge clk);
        bus8.dividend = a; bus8.divisor = b; bus8.start = 1'b1;
        sb8.push_back(model(8, {8'd0, a}, {8'd0, b}));
        @(posedge clk);
        #1 bus8.start = 1'b0;
        cyc = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus8.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus8.busy !== 1'b1) busy_bad++;
                if (cyc == inj) begin
                    bus8.start = 1'b1; bus8.dividend = 8'd50; bus8.divisor = 8'd5;
                end else begin
                    bus8.start = 1'b0;
                end
            end
        end
        chk("done_cyc8", 32'(cyc), 32'(lat));
        chk("busy_run8", 32'(busy_bad), 32'd0);
        chk("busy_at_done8", 32'(bus8.busy), 32'd0);
        if (sdone) begin
            bus8.start = 1'b1; bus8.dividend = 8'd99; bus8.divisor = 8'd1;
        end
        @(negedge clk);
        chk("done_pulse8", 32'(bus8.done), 32'd0);
        chk("idle_after8", 32'(bus8.busy), 32'd0);
        bus8.start = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int cyc;
        bit seen;
        @(negedge clk);
        bus16.dividend = a; bus16.divisor = b; bus16.start = 1'b1;
        sb16.push_back(model(16, a, b));
        @(posedge clk);
        #1 bus16.start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus16.done === 1'b1) seen = 1'b1;
        end
        chk("done_cyc16", 32'(cyc), (b == 16'd0) ? 32'd2 : 32'd17);
        @(negedge clk);
    endtask

    initial begin
        int spurious;
        logic [7:0] ra, rb;
        rst8_n = 1'b0; rst16_n = 1'b0;
        bus8.start = 1'b0;  bus8.dividend = 8'd0;   bus8.divisor = 8'd0;
        bus16.start = 1'b0; bus16.dividend = 16'd0; bus16.divisor = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus8.busy),        32'd0);
        chk("rst_done",  32'(bus8.done),        32'd0);
        chk("rst_q",     32'(bus8.quotient),    32'd0);
        chk("rst_r",     32'(bus8.remainder),   32'd0);
        chk("rst_dbz",   32'(bus8.div_by_zero), 32'd0);
        rst8_n = 1'b1; rst16_n = 1'b1;

        run8(8'd200, 8'd7,   0, 1'b0);
        run8(8'd255, 8'd255, 0, 1'b0);
        run8(8'd5,   8'd9,   0, 1'b0);
        run8(8'd0,   8'd3,   0, 1'b0);
        run8(8'd13,  8'd0,   0, 1'b0);
        run8(8'd40,  8'd8,   0, 1'b0);
        run8(8'd100, 8'd3,   4, 1'b1);
`ifdef DIVIDER_SIGNED_EN
        run8(8'h9C, 8'h07, 0, 1'b0);
        run8(8'h80, 8'hFF, 0, 1'b0);
        run8(8'h80, 8'h00, 0, 1'b0);
        run8(8'h07, 8'hFD, 0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            run8(ra, rb, 0, 1'b0);
        end

        run16(16'd54321, 16'd123);
        run16(16'd1000, 16'd0);

        // Abort a 16-bit run with reset during cycle 5.
        @(negedge clk);
        bus16.dividend = 16'd200; bus16.divisor = 16'd7; bus16.start = 1'b1;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst16_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus16.busy),        32'd0);
        chk("abort_done", 32'(bus16.done),        32'd0);
        chk("abort_q",    32'(bus16.quotient),    32'd0);
        chk("abort_r",    32'(bus16.remainder),   32'd0);
        chk("abort_dbz",  32'(bus16.div_by_zero), 32'd0);
        @(negedge clk);
        rst16_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) spurious++;
        end
        chk("abort_no_done", 32'(spurious), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb8_left",  32'(sb8.size()),  32'd0);
        chk("sb16_left", 32'(sb16.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
